// File: rtl/im_loader.sv
// Boot-time program loader: byte stream in, 16-bit words out to instruction memory.
// Holds the CPU in reset until a full image with a good checksum is written.
module im_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [7:0]        word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HI,
    S_LO,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [8:0] MAXW = 9'(MAX_WORDS);

  state_t     state;
  state_t     state_nx;
  logic [7:0] n_q;
  logic [7:0] hi_q;
  logic [7:0] csum_q;
  logic       acc;
  logic       idle_ish;
  logic       go;
  logic       hdr_bad;
  logic [7:0] wc_inc;

  assign acc      = byte_valid & byte_ready;
  assign idle_ish = (state == S_IDLE) | (state == S_DONE) | (state == S_ERR);
  assign go       = start & idle_ish;
  assign hdr_bad  = (byte_data == 8'd0) | ({1'b0, byte_data} > MAXW);
  assign wc_inc   = word_count + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE, S_DONE, S_ERR:
        if (start) state_nx = S_HDR;
      S_HDR:
        if (acc) state_nx = hdr_bad ? S_ERR : S_HI;
      S_HI:
        if (acc) state_nx = S_LO;
      S_LO:
        if (acc) state_nx = (wc_inc == n_q) ? S_CSUM : S_HI;
      S_CSUM:
        if (acc) state_nx = (byte_data == csum_q) ? S_DONE : S_ERR;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready = 1'b0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state)
      S_HDR, S_HI, S_LO, S_CSUM: byte_ready = 1'b1;
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR:   error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: header, checksum accumulator and the registered write port
  always_ff @(posedge clk) begin
    if (reset) begin
      n_q        <= '0;
      hi_q       <= '0;
      csum_q     <= '0;
      word_count <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
    end else begin
      im_we <= 1'b0;
      if (go) begin
        word_count <= '0;
        csum_q     <= '0;
      end
      if (acc) begin
        unique case (state)
          S_HDR: n_q <= byte_data;
          S_HI: begin
            hi_q   <= byte_data;
            csum_q <= csum_q ^ byte_data;
          end
          S_LO: begin
            im_we      <= 1'b1;
            im_addr    <= ADDR_W'({word_count, 1'b0});
            im_wdata   <= {hi_q, byte_data};
            csum_q     <= csum_q ^ byte_data;
            word_count <= wc_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Randomized self-checking bench for im_loader.
// A stream-level model predicts writes, outcome and word count.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [15:0] im_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [7:0]  word_count;

  int vec = 0;
  int err = 0;

  logic [7:0]  stream[$];
  logic [7:0]  cap_addr[$];
  logic [15:0] cap_data[$];
  logic [7:0]  cap_wc[$];
  logic [7:0]  exp_addr[$];
  logic [15:0] exp_data[$];
  logic        exp_done;
  logic        exp_err;
  logic [7:0]  exp_wc;

  im_loader #(.ADDR_W(8), .MAX_WORDS(128)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .im_we(im_we),
    .im_addr(im_addr),
    .im_wdata(im_wdata),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      cap_addr.push_back(im_addr);
      cap_data.push_back(im_wdata);
      cap_wc.push_back(word_count);
    end
  end

  task automatic model;
    int n;
    logic [7:0] cs;
    n = int'(stream[0]);
    cs = 8'h00;
    exp_addr.delete();
    exp_data.delete();
    if (n == 0 || n > 128) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      exp_wc   = 8'd0;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(8'((2 * i) % 256));
        exp_data.push_back({stream[1 + 2 * i], stream[2 + 2 * i]});
        cs = cs ^ stream[1 + 2 * i] ^ stream[2 + 2 * i];
      end
      exp_done = (stream[2 * n + 1] == cs);
      exp_err  = !exp_done;
      exp_wc   = 8'(n);
    end
  endtask

  task automatic build(input logic [7:0] hdr, input int nw, input bit bad);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    stream.delete();
    stream.push_back(hdr);
    for (int i = 0; i < 2 * nw; i++) begin
      b = 8'($urandom);
      cs ^= b;
      stream.push_back(b);
    end
    if (nw > 0) stream.push_back(bad ? ~cs : cs);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int gap, input int start_at, input int reset_at,
                      output bit aborted);
    int i;
    int cyc;
    logic rdy;
    i = 0;
    cyc = 0;
    aborted = 1'b0;
    while (i < stream.size() && cyc < 5000) begin
      byte_valid = ((cyc % gap) == 0);
      byte_data  = byte_valid ? stream[i] : 8'($urandom);
      start      = (cyc == start_at);
      reset      = (reset_at == i) && byte_valid;
      rdy        = byte_ready;
      @(posedge clk);
      if (byte_valid && rdy) i++;
      cyc++;
      @(negedge clk);
      if (reset) begin
        aborted = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    reset      = 1'b0;
    if (cyc >= 5000) begin
      err++;
      $display("FAIL send_timeout: %0d of %0d bytes accepted", i, stream.size());
    end
  endtask

  task automatic run_load(input string name, input int gap, input int start_at);
    bit ab;
    int m;
    cap_addr.delete();
    cap_data.delete();
    cap_wc.delete();
    pulse_start();
    send(gap, start_at, -1, ab);
    model();
    vec++;
    if (cap_addr.size() !== exp_addr.size()) begin
      err++;
      $display("FAIL %s_nwrites: got %0d want %0d", name, cap_addr.size(), exp_addr.size());
    end
    m = (cap_addr.size() < exp_addr.size()) ? cap_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      vec++;
      if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i] ||
          cap_wc[i] !== 8'(i + 1)) begin
        err++;
        $display("FAIL %s_write%0d: got %h/%h wc %0d want %h/%h wc %0d", name, i,
                 cap_addr[i], cap_data[i], cap_wc[i], exp_addr[i], exp_data[i], i + 1);
      end
    end
    vec++;
    if (done !== exp_done || error !== exp_err || cpu_hold !== !exp_done) begin
      err++;
      $display("FAIL %s_status: got d%b e%b h%b want d%b e%b h%b", name, done, error,
               cpu_hold, exp_done, exp_err, !exp_done);
    end
    vec++;
    if (word_count !== exp_wc || byte_ready !== 1'b0) begin
      err++;
      $display("FAIL %s_count: got %0d rdy %b want %0d rdy 0", name, word_count,
               byte_ready, exp_wc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) begin
      start      = 1'($urandom);
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
      @(negedge clk);
    end
    vec++;
    if (byte_ready !== 1'b0 || im_we !== 1'b0 || im_addr !== 8'h00 ||
        im_wdata !== 16'h0000) begin
      err++;
      $display("FAIL reset_port: got rdy%b we%b %h %h want 0 0 00 0000", byte_ready,
               im_we, im_addr, im_wdata);
    end
    vec++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0 || word_count !== 8'd0) begin
      err++;
      $display("FAIL reset_status: got h%b d%b e%b wc%0d want h1 d0 e0 wc0", cpu_hold,
               done, error, word_count);
    end
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    vec++;
    if (byte_ready !== 1'b0 || cap_addr.size() !== 0 || cpu_hold !== 1'b1 ||
        word_count !== 8'd0) begin
      err++;
      $display("FAIL idle_ignore: got rdy%b writes%0d h%b wc%0d want 0 0 1 0",
               byte_ready, cap_addr.size(), cpu_hold, word_count);
    end
  endtask

  task automatic test_good_load;
    stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load("good", 1, -1);
  endtask

  task automatic test_bad_checksum;
    stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    run_load("badcsum", 1, -1);
    stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load("recover", 1, -1);
  endtask

  task automatic test_bad_header;
    stream = '{8'h00};
    run_load("hdr00", 1, -1);
    stream = '{8'h81};
    run_load("hdr81", 1, -1);
    build(8'h80, 128, 1'b0);
    run_load("hdr80", 1, -1);
    vec++;
    if (cap_addr.size() != 128 || cap_addr[cap_addr.size() - 1] !== 8'hFE) begin
      err++;
      $display("FAIL max_last_addr: got %0d writes want 128 ending at fe", cap_addr.size());
    end
  endtask

  task automatic test_flow_control;
    stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    run_load("flow", 3, 7);
  endtask

  task automatic test_reset_mid_load;
    bit ab;
    stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    cap_addr.delete();
    cap_data.delete();
    cap_wc.delete();
    pulse_start();
    send(1, -1, 4, ab);
    repeat (3) @(negedge clk);
    vec++;
    if (!ab || word_count !== 8'd0 || byte_ready !== 1'b0 || cpu_hold !== 1'b1 ||
        done !== 1'b0) begin
      err++;
      $display("FAIL midrst_state: got ab%b wc%0d rdy%b h%b d%b want 1 0 0 1 0", ab,
               word_count, byte_ready, cpu_hold, done);
    end
    vec++;
    if (cap_addr.size() !== 1 || cap_data[0] !== 16'h1234) begin
      err++;
      $display("FAIL midrst_writes: got %0d writes want 1 of 1234", cap_addr.size());
    end
    run_load("after_rst", 1, -1);
  endtask

  task automatic test_random;
    int nw;
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        stream.delete();
        stream.push_back(8'($urandom_range(129, 255)));
      end else begin
        nw = $urandom_range(1, 8);
        build(8'(nw), nw, 1'($urandom_range(0, 1)));
      end
      run_load("rand", $urandom_range(1, 3), $urandom_range(0, 20));
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_bad_header();
    test_flow_control();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/im_loader.md
# im_loader

Boot-time program loader for the 16-bit pipelined CPU. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into the instruction memory's write port at byte addresses 0x00, 0x02, 0x04, and so on. This matches the fetch stage, which advances PC by 2. The loader holds the CPU in reset until a complete image with a correct checksum has been written.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory byte-address width
- MAX_WORDS, 128, maximum image length in words (2*MAX_WORDS must be <= 2^ADDR_W)

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a load session; sampled only in IDLE, DONE and ERR
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- im_we  out  1  instruction-memory write strobe, one cycle per word
- im_addr  out  ADDR_W  write byte address, always even
- im_wdata  out  16  instruction word, {hi_byte, lo_byte}
- cpu_hold  out  1  holds the CPU in reset; the CPU's reset is (reset | cpu_hold)
- done  out  1  image loaded and verified
- error  out  1  bad header or checksum mismatch
- word_count  out  8  number of words written in the current session

## Operation
- Stream format: header byte N (word count), then 2N payload bytes (each word high byte first), then one checksum byte.
- Checksum = XOR of all 2N payload bytes. The header is not included in the checksum.
- A byte is accepted on a clock edge where byte_valid & byte_ready = 1.
- States and transitions:
  - IDLE: byte_ready=0. start → HDR.
  - HDR: byte_ready=1. On accept, latch N.
    - N==0 or N>MAX_WORDS → ERR.
    - Otherwise → HI.
  - HI: byte_ready=1. On accept, hi ← byte, csum ^= byte → LO.
  - LO: byte_ready=1. On accept:
    - Register im_we=1, im_addr={word_count,1'b0} truncated to ADDR_W, im_wdata={hi,byte}.
    - csum ^= byte; word_count += 1.
    - If the new word_count == N → CSUM; otherwise → HI.
  - CSUM: byte_ready=1. On accept: byte==csum → DONE; otherwise → ERR.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start → HDR.
  - ERR: error=1, cpu_hold=1, byte_ready=0. start → HDR.
- On the start edge out of IDLE, DONE or ERR: clear word_count, csum, done and error; cpu_hold=1.
- start is ignored in HDR, HI, LO and CSUM.
- Bytes offered while byte_ready=0 are not consumed, and the loader has no side effects from them.
- cpu_hold=1 in every state except DONE.
- A checksum failure does not undo writes already made. Memory contents after ERR are undefined for CPU use; cpu_hold stays 1.
- Reset mid-session: go to IDLE on that edge. im_we=0 on the same edge, and no further writes occur. Already-written memory is untouched.

## Timing
- Reset values: state=IDLE, byte_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1, done=0, error=0, word_count=0.
- byte_ready is decoded from the registered state only; it has no combinational path from byte_valid.
- Throughput: one byte per cycle. An image of N words takes 2N+2 accepted bytes.
- im_we is high for exactly the one cycle after each LO accept. im_addr and im_wdata are valid in that cycle and hold their values afterwards.
- done and cpu_hold=0 take effect the cycle after the checksum accept. The final im_we occurs at least one cycle before done rises.
- error rises the cycle after the offending header or checksum accept.
- word_count updates on the LO-accept edge, coincident with im_we rising.

## Test plan
- Reset: assert reset for 2 cycles with random inputs → all outputs at reset values, cpu_hold=1, no im_we.
- Good load: start, then bytes 02,12,34,AB,CD,40 back-to-back → writes (0x00,0x1234) and (0x02,0xABCD), word_count=2, done=1, cpu_hold=0 one cycle after 40 is accepted.
- Bad checksum: same stream with final byte 41 → both writes occur, then error=1, done=0, cpu_hold=1. A following start plus the correct stream → done=1.
- Bad header: header 00 → error=1 with no im_we. Header 0x81 (129) → same. Header 0x80 with 256 payload bytes plus checksum → last write at 0xFE, done=1.
- Flow control: byte_valid asserted every third cycle, with start pulsed mid-load → identical writes and done to the good-load case; start has no effect mid-load.
- Reset mid-load: reset in the cycle after the first word's im_we → IDLE, no second write, word_count=0. A subsequent good load completes normally.
